// File: rtl/multi_debouncer.sv
// N-channel button debouncer: per-channel synchroniser, glitch filter,
// rise/fall event pulses and long-press (hold) detection on a shared tick.
module multi_debouncer #(
  parameter int N            = 4,
  parameter int BOUNCE_TICKS = 10,
  parameter int HOLD_TICKS   = 500,
  parameter int SYNC_STAGES  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_en,
  input  logic [N-1:0] bouncy_in,
  output logic [N-1:0] debounced_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] held,
  output logic [N-1:0] held_pulse
);

  localparam int BW = $clog2(BOUNCE_TICKS);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [BW-1:0] B_LAST = BW'(BOUNCE_TICKS - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(HOLD_TICKS);

  // Bit 1 of the state is the debounced level.
  localparam logic [1:0] STABLE_0 = 2'b00;
  localparam logic [1:0] MAYBE_1  = 2'b01;
  localparam logic [1:0] STABLE_1 = 2'b10;
  localparam logic [1:0] MAYBE_0  = 2'b11;

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= bouncy_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]    state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          hi_q, hi_d;
    logic          rise_q, fall_q, hp_q;
    logic          s;

    assign s    = sync_in[i];
    assign hi_q = state_q[1];
    assign hi_d = state_d[1];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        STABLE_0: begin
          if (s) begin
            state_d = MAYBE_1;
            cnt_d   = '0;
          end
        end
        MAYBE_1: begin
          if (!s) begin
            state_d = STABLE_0;
          end else if (tick_en) begin
            if (cnt_q == B_LAST) begin
              state_d = STABLE_1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        STABLE_1: begin
          if (!s) begin
            state_d = MAYBE_0;
            cnt_d   = '0;
          end
        end
        MAYBE_0: begin
          if (s) begin
            state_d = STABLE_1;
          end else if (tick_en) begin
            if (cnt_q == B_LAST) begin
              state_d = STABLE_0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = STABLE_0;
          cnt_d   = '0;
        end
      endcase
    end

    // Counting starts the cycle after rise so held lands HOLD_TICKS later.
    always_comb begin
      hold_d = hold_q;
      if (!hi_d || !hi_q) begin
        hold_d = '0;
      end else if (tick_en && hold_q != H_MAX) begin
        hold_d = hold_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= STABLE_0;
        cnt_q   <= '0;
        hold_q  <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        hp_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        rise_q  <= hi_d & ~hi_q;
        fall_q  <= ~hi_d & hi_q;
        hp_q    <= (hold_d == H_MAX) && (hold_q != H_MAX);
      end
    end

    assign debounced_out[i] = hi_q;
    assign rise[i]          = rise_q;
    assign fall[i]          = fall_q;
    assign held[i]          = (hold_q == H_MAX);
    assign held_pulse[i]    = hp_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: vector table plus hand sequences
// for bounce, slow timebase, hold retention and mid-operation reset.
module tb_multi_debouncer;

  logic       clk;
  logic       rst;
  logic       tick_en;
  logic [3:0] bouncy_in;
  logic [3:0] debounced_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] held;
  logic [3:0] held_pulse;

  int total;
  int bad;

  multi_debouncer #(
    .N           (4),
    .BOUNCE_TICKS(10),
    .HOLD_TICKS  (20),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_en      (tick_en),
    .bouncy_in    (bouncy_in),
    .debounced_out(debounced_out),
    .rise         (rise),
    .fall         (fall),
    .held         (held),
    .held_pulse   (held_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bin;
    int         cyc;
    logic [3:0] db;
    logic [3:0] ri;
    logic [3:0] fa;
    logic [3:0] hd;
    logic [3:0] hp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [3:0] bin, int cyc,
                              logic [3:0] db, logic [3:0] ri,
                              logic [3:0] fa, logic [3:0] hd,
                              logic [3:0] hp);
    vec_t v;
    v.bin = bin;
    v.cyc = cyc;
    v.db  = db;
    v.ri  = ri;
    v.fa  = fa;
    v.hd  = hd;
    v.hp  = hp;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] db,
                         input logic [3:0] ri, input logic [3:0] fa,
                         input logic [3:0] hd, input logic [3:0] hp);
    chk({nm, " db"}, int'(debounced_out), int'(db));
    chk({nm, " rise"}, int'(rise), int'(ri));
    chk({nm, " fall"}, int'(fall), int'(fa));
    chk({nm, " held"}, int'(held), int'(hd));
    chk({nm, " hpulse"}, int'(held_pulse), int'(hp));
  endtask

  // Slow timebase: tick on every 4th clock, a 3-clock glitch aborts MAYBE.
  task automatic ch3_run(input logic val, input bit glitch,
                         input int ecnt, input string nm);
    int early;
    early = 0;
    for (int e = 1; e <= ecnt; e++) begin
      tick_en      = (e % 4 == 0);
      bouncy_in[3] = (glitch && e >= 21 && e <= 23) ? ~val : val;
      step();
      if (e < ecnt && (debounced_out[3] != ~val || rise[3] || fall[3]))
        early++;
    end
    chk({nm, " early"}, early, 0);
    chk({nm, " level"}, int'(debounced_out[3]), int'(val));
    chk({nm, " pulse"}, int'(val ? rise[3] : fall[3]), 1);
  endtask

  initial begin
    int errs;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    tick_en   = 1'b1;
    bouncy_in = 4'b0000;

    tv.push_back(mk(4'b0000,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b0100, 12, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b0100,  1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b0100, 18, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100));
    tv.push_back(mk(4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000));
    tv.push_back(mk(4'b0000, 12, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000));
    tv.push_back(mk(4'b0000,  1, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b1111, 12, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b1111,  1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b1110, 12, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b1110,  1, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b1110,  6, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b1110,  1, 4'b1110, 4'b0000, 4'b0000, 4'b1110, 4'b1110));
    tv.push_back(mk(4'b1110,  1, 4'b1110, 4'b0000, 4'b0000, 4'b1110, 4'b0000));
    tv.push_back(mk(4'b0000, 13, 4'b0000, 4'b0000, 4'b1110, 4'b0000, 4'b0000));
    tv.push_back(mk(4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));

    repeat (3) step();
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;

    foreach (tv[k]) begin
      bouncy_in = tv[k].bin;
      repeat (tv[k].cyc) step();
      chk_all($sformatf("vec%0d", k), tv[k].db, tv[k].ri,
              tv[k].fa, tv[k].hd, tv[k].hp);
    end

    // Bounce on ch0: 3-clock toggling never settles.
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      bouncy_in[0] = ((i / 3) % 2 == 0);
      step();
      if (rise != 4'b0000 || debounced_out != 4'b0000) errs++;
    end
    chk("bounce quiet", errs, 0);
    bouncy_in[0] = 1'b1;
    repeat (12) step();
    chk("bounce pre", int'(debounced_out), 0);
    step();
    chk("bounce rise", int'(rise), 1);
    chk("bounce db", int'(debounced_out), 1);
    bouncy_in[0] = 1'b0;
    repeat (14) step();
    chk("bounce release", int'(debounced_out), 0);

    ch3_run(1'b1, 1'b0, 40, "tb rise");
    ch3_run(1'b0, 1'b1, 64, "tb glitch fall");
    ch3_run(1'b1, 1'b1, 64, "tb glitch rise");
    ch3_run(1'b0, 1'b0, 40, "tb fall");
    tick_en = 1'b1;

    // Hold on ch1, then a short release that must not clear the hold.
    bouncy_in = 4'b0010;
    repeat (13) step();
    chk("hold rise", int'(rise), 4'b0010);
    repeat (20) step();
    chk("hold held", int'(held), 4'b0010);
    chk("hold hpulse", int'(held_pulse), 4'b0010);
    errs = 0;
    bouncy_in = 4'b0000;
    repeat (4) begin
      step();
      if (!held[1] || fall[1] || held_pulse[1]) errs++;
    end
    bouncy_in = 4'b0010;
    repeat (4) begin
      step();
      if (!held[1] || fall[1] || held_pulse[1]) errs++;
    end
    chk("hold keep", errs, 0);

    // Reset with ch0 at count 7 in MAYBE_1 and ch1 held.
    bouncy_in = 4'b0011;
    repeat (10) step();
    rst = 1'b0;
    step();
    chk_all("midrst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    errs = 0;
    for (int e = 1; e <= 13; e++) begin
      step();
      if (fall != 4'b0000 || held_pulse != 4'b0000) errs++;
      if (e == 12) chk("midrst pre", int'(debounced_out), 0);
    end
    chk("midrst nofall", errs, 0);
    chk("midrst db", int'(debounced_out), 4'b0011);
    chk("midrst rise", int'(rise), 4'b0011);
    chk("midrst held", int'(held), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
